// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch port, data port, memory bus and stall signals of the shared memory arbiter.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        flush;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_mem;

    modport slave (
        input  i_req, i_addr, flush, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_done, d_rdata, d_done, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
               stall_if, stall_mem
    );

    modport master (
        output i_req, i_addr, flush, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_done, d_rdata, d_done, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
               stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (I) and memory stage (D), D-priority with anti-starvation.
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DRAIN} state_t;

    state_t        state;
    logic [SW-1:0] d_streak;
    logic          arb;
    logic          i_cand;
    logic          d_cand;
    logic          streak_full;
    logic          grant_i;
    logic          grant_d;

    // The port finishing this cycle cannot win again until the next cycle; flush hides any fetch.
    always_comb begin
        arb         = state == IDLE || bus.mem_ready;
        i_cand      = bus.i_req && !bus.flush && state != BUSY_I;
        d_cand      = bus.d_req && state != BUSY_D;
        streak_full = d_streak == SW'(MAX_D_STREAK);
        grant_i     = arb && i_cand && (!d_cand || streak_full);
        grant_d     = arb && d_cand && !grant_i;
    end

    assign bus.i_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
    assign bus.i_done    = bus.mem_ready && state == BUSY_I && !bus.flush;
    assign bus.d_done    = bus.mem_ready && state == BUSY_D;
    assign bus.stall_if  = bus.i_req && !bus.i_done;
    assign bus.stall_mem = bus.d_req && !bus.d_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            d_streak      <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= 4'h0;
            bus.mem_addr  <= 32'h0;
            bus.mem_wdata <= 32'h0;
        end else if (arb) begin
            state       <= grant_i ? BUSY_I : grant_d ? BUSY_D : IDLE;
            bus.mem_req <= grant_i || grant_d;
            if (grant_i) begin
                bus.mem_we    <= 1'b0;
                bus.mem_be    <= 4'hF;
                bus.mem_addr  <= bus.i_addr;
                bus.mem_wdata <= 32'h0;
            end
            if (grant_d) begin
                bus.mem_we    <= bus.d_we;
                bus.mem_be    <= bus.d_be;
                bus.mem_addr  <= bus.d_addr;
                bus.mem_wdata <= bus.d_wdata;
            end
            if (grant_i || !bus.i_req)
                d_streak <= '0;
            else if (grant_d && !bus.flush && !streak_full)
                d_streak <= d_streak + 1'b1;
        end else if (state == BUSY_I && bus.flush) begin
            state <= DRAIN;
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified memory between the fetch stage (I-port) and the memory stage (D-port) of the pipelined MIPS core. It grants one transaction at a time, drives the memory bus, and routes read data back to the requester. It raises per-stage stall signals that the pipeline control merges with the load-use stall, and it discards fetches cancelled by a branch redirect.

## Interface
- MAX_D_STREAK, 4: maximum consecutive D grants while an I request waits; must be ≥1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request; held high until i_done.
- i_addr  in  32  fetch address, word aligned.
- i_rdata  out  32  fetched word; valid only when i_done=1.
- i_done  out  1  fetch completes this cycle.
- flush  in  1  branch redirect; cancels any pending or in-flight fetch.
- d_req  in  1  load/store request; held high until d_done.
- d_we  in  1  1 = store.
- d_be  in  4  store byte enables.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data; valid only when d_done=1.
- d_done  out  1  data access completes this cycle.
- mem_req  out  1  memory transaction active.
- mem_we, mem_be, mem_addr, mem_wdata  out  1/4/32/32  registered copies of the granted request.
- mem_rdata  in  32  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completes the current transaction this cycle; ≥1 cycle after mem_req rises.
- stall_if  out  1  = i_req & ~i_done.
- stall_mem  out  1  = d_req & ~d_done.

## Operation
- States: IDLE, BUSY_I, BUSY_D, DRAIN (cancelled fetch still in flight).
- Arbitration happens in IDLE, and in the completion cycle of BUSY_I, BUSY_D, or DRAIN (mem_ready=1). The requester completing in that cycle is excluded; its req is treated as a new request from the following cycle.
- Priority: D over I, except when i_req=1 and d_streak==MAX_D_STREAK, in which case I is granted.
- d_streak: +1 on each D grant while i_req=1 and flush=0. Cleared on an I grant, or on any arbitration with i_req=0. Saturates at MAX_D_STREAK. Width $clog2(MAX_D_STREAK+1).
- On a grant, mem_we/mem_be/mem_addr/mem_wdata are latched from the granted port and held constant until mem_ready. For an I grant: mem_we=0, mem_be=4'hF, mem_wdata=0.
- i_rdata and d_rdata are direct pass-throughs of mem_rdata. i_done = mem_ready & (state==BUSY_I). d_done = mem_ready & (state==BUSY_D).
- Flush:
  - In BUSY_I, flush=1 without mem_ready moves the state to DRAIN. The transaction runs to mem_ready, and i_done stays 0.
  - Flush coinciding with mem_ready in BUSY_I forces i_done=0, and the word is dropped.
  - In any cycle with flush=1, i_req is ignored for arbitration.
- DRAIN on mem_ready: no done pulse; arbitration proceeds as normal.
- A store to the address being fetched needs no ordering logic; the transactions are strictly serialized.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, d_streak=0. i_done, d_done, stall_if, and stall_mem follow from their equations (done=0).
- Reset mid-transaction abandons it immediately. The memory must accept mem_req dropping without mem_ready.
- Grant latency: request seen at edge N (IDLE) gives mem_req=1 from cycle N+1.
- Minimum access is 2 cycles from request (grant, then mem_ready). done and data appear in the mem_ready cycle.
- Back-to-back: a completion at cycle K that grants the other port gives mem_req=1 continuously, with the new address from K+1.
- When nothing is pending at completion, mem_req=0 from K+1.
- Simultaneous first request of both ports in IDLE with d_streak<MAX: D is granted.

## Test plan
- Lone fetch: i_req=1, i_addr=0x0040_0000, mem_ready one cycle after mem_req, mem_rdata=0x2402_0005 -> i_done=1 in cycle 2, i_rdata=0x2402_0005, stall_if=1 in cycles 0–1.
- Contention: i_req and d_req both rise at cycle 0, d_we=1, d_addr=0x1000_0010, d_wdata=0xDEAD_BEEF, d_be=4'b0011 -> D serviced first with mem_we=1 and mem_be=4'b0011, then I back-to-back with no idle cycle.
- Starvation: i_req held while d_req is re-raised every completion, with MAX_D_STREAK=4 -> exactly 4 D grants, then an I grant, then D again.
- Flush in flight: flush pulses in the cycle after an I grant, with mem_ready 3 cycles later -> state DRAIN, i_done never 1, the next grant follows that mem_ready.
- Flush coinciding with mem_ready -> i_done=0. An I request raised in the same cycle is not granted until the next cycle.
- Async reset asserted while BUSY_D with mem_ready low -> mem_req=0 and all mem_* outputs=0 immediately. After release, d_req is re-arbitrated from IDLE.
